// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: NUM_RD-read / 1-write register file with write-through bypass,
// per-port forwarding and an in-flight scoreboard. Optional debug port: RF_DBG_PORT_EN.
module regfile_mp_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    input  logic [NUM_RD-1:0]    fwd_vld,
    input  logic [NUM_RD*DW-1:0] fwd_data,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        wdata,
    input  logic                 iss_vld,
    input  logic [AW-1:0]        iss_rd,
    output logic                 sb_err
`ifdef RF_DBG_PORT_EN
    ,
    input  logic [AW-1:0]        dbg_addr,
    output logic [DW-1:0]        dbg_data,
    output logic [CNT_W-1:0]     dbg_cnt
`endif
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0]    regs [DEPTH];
    logic [CNT_W-1:0] cnt  [DEPTH];

    logic wr_ok;
    logic iss_ok;
    logic same_reg;
    logic ovf;
    logic udf;

    // Writes to a hardwired zero register neither store nor retire a producer.
    always_comb begin
        wr_ok    = we && !((ZERO_REG != 0) && (waddr == '0));
        iss_ok   = iss_vld && !((ZERO_REG != 0) && (iss_rd == '0));
        same_reg = wr_ok && iss_ok && (waddr == iss_rd);
        ovf      = iss_ok && !same_reg && (cnt[iss_rd] == '1);
        udf      = wr_ok && !same_reg && (cnt[waddr] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[waddr] <= wdata;
            end
            // same_reg excluded, so the two counter updates never hit one entry.
            if (iss_ok && !same_reg && !ovf) begin
                cnt[iss_rd] <= cnt[iss_rd] + 1'b1;
            end
            if (wr_ok && !same_reg && !udf) begin
                cnt[waddr] <= cnt[waddr] - 1'b1;
            end
            if (ovf || udf) begin
                sb_err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          zero;
        logic          hit_w;
        logic          last_w;

        assign addr   = rd_addr[i*AW +: AW];
        assign zero   = (ZERO_REG != 0) && (addr == '0);
        assign hit_w  = we && (waddr == addr);
        assign last_w = hit_w && (cnt[addr] == CNT_W'(1));

        assign rd_data[i*DW +: DW] = zero       ? '0 :
                                     fwd_vld[i] ? fwd_data[i*DW +: DW] :
                                     hit_w      ? wdata :
                                                  regs[addr];

        assign rd_busy[i] = !zero && !fwd_vld[i] && (cnt[addr] != '0) && !last_w;
    end

`ifdef RF_DBG_PORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data <= '0;
            dbg_cnt  <= '0;
        end else begin
            dbg_data <= regs[dbg_addr];
            dbg_cnt  <= cnt[dbg_addr];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed vector table, hand-written
// hazard/overflow/reset sequences and randomized traffic against a reference model.
module tb_regfile_mp_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int CW    = 2;
    localparam int DEPTH = 32;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR*AW-1:0] rd_addr;
    logic [NR-1:0]    fwd_vld;
    logic [NR*DW-1:0] fwd_data;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic             iss_vld;
    logic [AW-1:0]    iss_rd;
    logic             sb_err;

    regfile_mp_sb #(.DW(DW), .AW(AW), .NUM_RD(NR), .ZERO_REG(1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .fwd_vld(fwd_vld),
        .fwd_data(fwd_data), .rd_data(rd_data), .rd_busy(rd_busy), .we(we),
        .waddr(waddr), .wdata(wdata), .iss_vld(iss_vld), .iss_rd(iss_rd),
        .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    // Reference model: stored values, outstanding-producer counts, sticky error.
    logic [31:0] m_reg [DEPTH];
    int          m_cnt [DEPTH];
    bit          m_err;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        bit          w;
        int          wa;
        logic [31:0] wd;
        bit          iv;
        int          ir;
        int          a0;
        int          a1;
        logic [1:0]  fv;
        logic [31:0] f0;
        logic [31:0] f1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        bit          ee;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic set_in(input bit w, input int wa, input logic [31:0] wd,
                          input bit iv, input int ir, input int a0, input int a1,
                          input logic [1:0] fv, input logic [31:0] f0, input logic [31:0] f1);
        we       = w;
        waddr    = AW'(wa);
        wdata    = wd;
        iss_vld  = iv;
        iss_rd   = AW'(ir);
        rd_addr  = {AW'(a1), AW'(a0)};
        fwd_vld  = fv;
        fwd_data = {f1, f0};
    endtask

    function automatic logic [31:0] exp_data(input int p);
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        if (a == 0) return '0;
        if (fwd_vld[p]) return fwd_data[p*DW +: DW];
        if (we && int'(waddr) == a) return wdata;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input int p);
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        if (a == 0 || fwd_vld[p]) return 1'b0;
        if (m_cnt[a] == 0) return 1'b0;
        if (we && int'(waddr) == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    // Apply the clock-edge effect of the currently driven inputs to the model.
    task automatic model_edge();
        int wi;
        int ii;
        bit w_ok;
        bit i_ok;
        wi   = int'(waddr);
        ii   = int'(iss_rd);
        w_ok = we && wi != 0;
        i_ok = iss_vld && ii != 0;
        if (w_ok) m_reg[wi] = wdata;
        if (!(w_ok && i_ok && wi == ii)) begin
            if (i_ok) begin
                if (m_cnt[ii] == CMAX) m_err = 1'b1;
                else m_cnt[ii]++;
            end
            if (w_ok) begin
                if (m_cnt[wi] == 0) m_err = 1'b1;
                else m_cnt[wi]--;
            end
        end
    endtask

    task automatic check_model(input string tag);
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("%s data%0d", tag, p), rd_data[p*DW +: DW], exp_data(p));
            chk($sformatf("%s busy%0d", tag, p), 32'(rd_busy[p]), 32'(exp_busy(p)));
        end
        chk($sformatf("%s sb_err", tag), 32'(sb_err), 32'(m_err));
    endtask

    // Inputs already driven after a falling edge: compare, advance model, take the edge.
    task automatic tick_model(input string tag);
        #1;
        check_model(tag);
        model_edge();
        @(posedge clk);
    endtask

    task automatic run(input bit w, input int wa, input logic [31:0] wd,
                       input bit iv, input int ir, input int a0, input int a1,
                       input logic [1:0] fv, input logic [31:0] f0, input logic [31:0] f1,
                       input string tag);
        @(negedge clk);
        set_in(w, wa, wd, iv, ir, a0, a1, fv, f0, f1);
        tick_model(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            w  wa wd            iv ir a0 a1 fv     f0            f1            e0            e1            eb     ee
        tbl[0]  = '{0, 0, 32'h0,        1, 5, 5, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 0};
        tbl[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 2'b00, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        2'b00, 0};
        tbl[2]  = '{0, 0, 32'h0,        0, 0, 5, 5, 2'b00, 32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0};
        tbl[3]  = '{1, 0, 32'h12345678, 0, 0, 0, 5, 2'b00, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF, 2'b00, 0};
        tbl[4]  = '{0, 0, 32'h0,        0, 0, 0, 0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        2'b00, 0};
        tbl[5]  = '{0, 0, 32'h0,        1, 7, 7, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 0};
        tbl[6]  = '{0, 0, 32'h0,        1, 7, 7, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        2'b01, 0};
        tbl[7]  = '{0, 0, 32'h0,        0, 0, 7, 7, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        2'b11, 0};
        tbl[8]  = '{1, 7, 32'h11111111, 0, 0, 7, 0, 2'b00, 32'h0,        32'h0,        32'h11111111, 32'h0,        2'b01, 0};
        tbl[9]  = '{1, 7, 32'h22222222, 0, 0, 7, 7, 2'b00, 32'h0,        32'h0,        32'h22222222, 32'h22222222, 2'b00, 0};
        tbl[10] = '{0, 0, 32'h0,        0, 0, 7, 7, 2'b00, 32'h0,        32'h0,        32'h22222222, 32'h22222222, 2'b00, 0};
        tbl[11] = '{0, 0, 32'h0,        1, 4, 4, 4, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 0};
        tbl[12] = '{1, 4, 32'h44444444, 1, 4, 4, 4, 2'b00, 32'h0,        32'h0,        32'h44444444, 32'h44444444, 2'b00, 0};
        tbl[13] = '{0, 0, 32'h0,        0, 0, 4, 4, 2'b00, 32'h0,        32'h0,        32'h44444444, 32'h44444444, 2'b11, 0};
        tbl[14] = '{0, 0, 32'h0,        0, 0, 4, 4, 2'b01, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h44444444, 2'b10, 0};
        tbl[15] = '{1, 4, 32'h55555555, 1, 4, 4, 4, 2'b10, 32'h0,        32'hCAFEF00D, 32'h55555555, 32'hCAFEF00D, 2'b00, 0};
        tbl[16] = '{0, 0, 32'h0,        0, 0, 4, 0, 2'b00, 32'h0,        32'h0,        32'h55555555, 32'h0,        2'b01, 0};

        model_reset();
        set_in(0, 0, '0, 0, 0, 0, 0, 2'b00, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            run(0, 0, '0, 0, 0, a, DEPTH - 1 - a, 2'b00, '0, '0, $sformatf("reset x%0d", a));
        end

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            set_in(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].iv, tbl[i].ir,
                   tbl[i].a0, tbl[i].a1, tbl[i].fv, tbl[i].f0, tbl[i].f1);
            #1;
            chk($sformatf("vec%0d data0", i), rd_data[31:0], tbl[i].e0);
            chk($sformatf("vec%0d data1", i), rd_data[63:32], tbl[i].e1);
            chk($sformatf("vec%0d busy", i), 32'(rd_busy), 32'(tbl[i].eb));
            chk($sformatf("vec%0d sb_err", i), 32'(sb_err), 32'(tbl[i].ee));
            model_edge();
            @(posedge clk);
        end

        // Saturating overflow on x3, then underflow on idle x9.
        for (int k = 0; k < 4; k++) run(0, 0, '0, 1, 3, 3, 9, 2'b00, '0, '0, $sformatf("ovf iss%0d", k));
        @(negedge clk);
        set_in(0, 0, '0, 0, 0, 3, 9, 2'b00, '0, '0);
        #1;
        chk("ovf sticky", 32'(sb_err), 32'd1);
        chk("ovf x3 busy", 32'(rd_busy[0]), 32'd1);
        tick_model("ovf idle");
        run(1, 9, 32'h99999999, 0, 0, 9, 3, 2'b00, '0, '0, "udf x9");
        run(0, 0, '0, 1, 9, 9, 0, 2'b00, '0, '0, "x9 iss");
        run(0, 0, '0, 0, 0, 9, 0, 2'b00, '0, '0, "x9 busy");
        for (int k = 0; k < 3; k++) run(1, 3, 32'h30 + 32'(k), 0, 0, 3, 3, 2'b00, '0, '0, $sformatf("drain x3 w%0d", k));
        run(0, 0, '0, 0, 0, 3, 9, 2'b00, '0, '0, "drained");

        // Asynchronous reset in the middle of an issue/write burst.
        run(0, 0, '0, 1, 3, 3, 7, 2'b00, '0, '0, "burst0");
        run(0, 0, '0, 1, 3, 3, 7, 2'b00, '0, '0, "burst1");
        @(negedge clk);
        set_in(1, 7, 32'h77777777, 1, 3, 3, 7, 2'b00, '0, '0);
        #1;
        check_model("pre-rst");
        #1;
        rst_n = 1'b0;
        #1;
        set_in(0, 0, '0, 0, 0, 3, 7, 2'b00, '0, '0);
        #1;
        chk("async rst sb_err", 32'(sb_err), 32'd0);
        chk("async rst busy", 32'(rd_busy), 32'd0);
        chk("async rst data0", rd_data[31:0], 32'd0);
        chk("async rst data1", rd_data[63:32], 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 0, '0, 0, 0, 3, 7, 2'b00, '0, '0, "post-rst");

        // Randomized traffic: writes mostly retire outstanding issues in order.
        begin
            int q[$];
            for (int n = 0; n < 500; n++) begin
                bit          w;
                bit          iv;
                int          wa;
                int          ir;
                logic [1:0]  fv;
                iv = ($urandom_range(99) < 45);
                ir = int'($urandom_range(7));
                w  = ($urandom_range(99) < 45);
                if (w && q.size() > 0 && $urandom_range(9) < 8) wa = q.pop_front();
                else wa = int'($urandom_range(7));
                if (iv && q.size() < 16) q.push_back(ir);
                fv[0] = ($urandom_range(3) == 0);
                fv[1] = ($urandom_range(3) == 0);
                run(w, wa, $urandom, iv, ir, int'($urandom_range(9)), int'($urandom_range(9)),
                    fv, $urandom, $urandom, $sformatf("rnd%0d", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
